// File: rtl/merge_tree_pkg.sv
// merge_tree_pkg: shared widths, record word type and beat helpers for the merge tree
package merge_tree_pkg;
  localparam int KEEP_MAX = 512;
  localparam int REC_W = 64;
  typedef struct packed {
    logic last;
    logic [REC_W-1:0] record;
  } rec_word_t;
  function automatic int records_per_beat(input int axis_w, input int rec_w);
    return axis_w / rec_w;
  endfunction
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int slot, input int rec_bytes = REC_W / 8);
    return {KEEP_MAX{1'b1}} >> (KEEP_MAX - (slot + 1) * rec_bytes);
  endfunction
endpackage

// File: rtl/merge_tree_collect.sv
// merge_tree_collect: packs the root {last, record} stream into AXI4-Stream beats
module merge_tree_collect
  import merge_tree_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int RECORD_DATA_WIDTH = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [RECORD_DATA_WIDTH:0]    i_data,
  input  logic                          i_data_vld,
  output logic                          o_read,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                          m_axis_tlast
);
  localparam int RPB = records_per_beat(AXIS_TDATA_WIDTH, RECORD_DATA_WIDTH);
  localparam int SW = $clog2(RPB);
  localparam int KW = AXIS_TDATA_WIDTH / 8;
  if (AXIS_TDATA_WIDTH % RECORD_DATA_WIDTH != 0 || RECORD_DATA_WIDTH % 8 != 0 ||
      RPB < 2 || (RPB & (RPB - 1)) != 0) begin : g_bad_params
    $error("merge_tree_collect: invalid AXIS_TDATA_WIDTH/RECORD_DATA_WIDTH");
  end
  logic [SW-1:0] slot;
  logic [RPB-2:0][RECORD_DATA_WIDTH-1:0] pack;
  logic [RPB-1:0][RECORD_DATA_WIDTH-1:0] beat;
  logic [RECORD_DATA_WIDTH-1:0] rec;
  logic last;
  logic closing;
  assign rec = i_data[RECORD_DATA_WIDTH-1:0];
  assign last = i_data[RECORD_DATA_WIDTH];
  assign closing = last || slot == SW'(RPB - 1);
  assign o_read = i_rst_n && i_data_vld && (!closing || !m_axis_tvalid || m_axis_tready);
  for (genvar k = 0; k < RPB - 1; k++) begin : g_lane
    assign beat[k] = SW'(k) == slot ? rec : SW'(k) < slot ? pack[k] : '0;
  end
  assign beat[RPB-1] = slot == SW'(RPB - 1) ? rec : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      slot <= '0;
      pack <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      if (o_read) slot <= closing ? '0 : slot + 1'b1;
      for (int k = 0; k < RPB - 1; k++)
        if (o_read && !closing && slot == SW'(k)) pack[k] <= rec;
      if (o_read && closing) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= beat;
        m_axis_tkeep <= KW'(keep_mask(int'(slot), RECORD_DATA_WIDTH / 8));
        m_axis_tlast <= last;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_merge_tree_collect.sv
// tb_merge_tree_collect: scoreboard bench for the merge tree root collector
module tb_merge_tree_collect;
  import merge_tree_pkg::*;
  typedef struct {
    logic [511:0] d;
    logic [63:0] k;
    logic l;
    int c;
  } beat_t;
  logic i_clk;
  logic i_rst_n;
  rec_word_t i_data;
  logic i_data_vld;
  logic o_read;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0] m_axis_tkeep;
  logic m_axis_tlast;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  bit rnd = 0;
  beat_t exp_q[$];
  beat_t seen[$];
  merge_tree_collect #(.AXIS_TDATA_WIDTH(512), .RECORD_DATA_WIDTH(64)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_data(i_data),
    .i_data_vld(i_data_vld),
    .o_read(o_read),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast)
  );
  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end
  function automatic logic [63:0] lane(input logic [511:0] d, input int k);
    return d[64*k +: 64];
  endfunction
  task automatic monitor();
    beat_t e;
    beat_t b;
    logic [63:0] pk [8];
    int pn = 0;
    logic hold = 0;
    logic [511:0] hd = '0;
    logic [63:0] hk = '0;
    logic hl = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_rst_n) begin
        pn = 0;
        exp_q.delete();
        hold = 0;
      end else begin
        if (hold) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tkeep !== hk || m_axis_tlast !== hl) begin
            errors++;
            $display("FAIL axis_stable: got tvalid=%b tkeep=%h tlast=%b lane0=%h, held tkeep=%h tlast=%b lane0=%h",
                     m_axis_tvalid, m_axis_tkeep, m_axis_tlast, lane(m_axis_tdata, 0), hk, hl, lane(hd, 0));
          end
        end
        if (i_data_vld && o_read) begin
          n_acc++;
          pk[pn] = i_data.record;
          if (i_data.last || pn == 7) begin
            e.d = '0;
            e.k = '0;
            for (int j = 0; j <= pn; j++) begin
              e.d[64*j +: 64] = pk[j];
              e.k[8*j +: 8] = 8'hFF;
            end
            e.l = i_data.last;
            e.c = 0;
            exp_q.push_back(e);
            pn = 0;
          end else pn++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          b.d = m_axis_tdata;
          b.k = m_axis_tkeep;
          b.l = m_axis_tlast;
          b.c = cyc;
          seen.push_back(b);
          n_out += $countones(m_axis_tkeep) / 8;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got beat lane0=%h tkeep=%h, required no beat", lane(b.d, 0), b.k);
          end else begin
            e = exp_q.pop_front();
            if (b.d !== e.d || b.k !== e.k || b.l !== e.l)
              begin
                errors++;
                $display("FAIL sb_beat: got lane0=%h lane7=%h tkeep=%h tlast=%b, required lane0=%h lane7=%h tkeep=%h tlast=%b",
                         lane(b.d, 0), lane(b.d, 7), b.k, b.l, lane(e.d, 0), lane(e.d, 7), e.k, e.l);
              end
          end
        end
        hold = m_axis_tvalid && !m_axis_tready;
        hd = m_axis_tdata;
        hk = m_axis_tkeep;
        hl = m_axis_tlast;
      end
    end
  endtask
  task automatic send(input logic [63:0] d, input logic l);
    int n = 0;
    i_data = '{last: l, record: d};
    i_data_vld = 1;
    @(negedge i_clk);
    while (!o_read && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_read) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got o_read=0 for 200 cycles, required 1 (record %h)", d);
    end
    @(posedge i_clk);
    #1;
    i_data_vld = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  task automatic test_reset();
    i_rst_n = 0;
    i_data = '{last: 1'b1, record: 64'h55};
    i_data_vld = 1;
    m_axis_tready = 1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b, required 0", o_read); end
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got tvalid=%b tlast=%b, required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
      errors++; $display("FAIL reset_data: got tkeep=%h lane0=%h, required 0 0", m_axis_tkeep, lane(m_axis_tdata, 0));
    end
    @(posedge i_clk);
    #3;
    i_data_vld = 0;
    i_rst_n = 1;
    idle(1);
  endtask
  task automatic test_two_beats();
    m_axis_tready = 1;
    seen.delete();
    for (int i = 1; i <= 16; i++) send(64'(i), i == 16);
    idle(3);
    checks++;
    if (seen.size() != 2) begin
      errors++; $display("FAIL two_beats_count: got %0d beats, required 2", seen.size());
    end else begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (lane(seen[b].d, k) !== 64'(k + 1 + 8 * b)) begin
            errors++; $display("FAIL two_beats_lane: beat %0d lane %0d got %h, required %h", b, k, lane(seen[b].d, k), k + 1 + 8 * b);
          end
        end
      checks++;
      if (seen[0].k !== '1 || seen[1].k !== '1 || seen[0].l !== 1'b0 || seen[1].l !== 1'b1) begin
        errors++; $display("FAIL two_beats_keep: got %h/%b %h/%b, required all-ones/0 all-ones/1", seen[0].k, seen[0].l, seen[1].k, seen[1].l);
      end
      checks++;
      if (seen[1].c - seen[0].c != 8) begin
        errors++; $display("FAIL two_beats_spacing: got %0d cycles, required 8", seen[1].c - seen[0].c);
      end
    end
  endtask
  task automatic test_partial();
    m_axis_tready = 1;
    seen.delete();
    send(64'hA, 0);
    send(64'hB, 0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL partial_early: got tvalid=%b, required 0", m_axis_tvalid); end
    send(64'hC, 1);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL partial_latency: got tvalid=%b, required 1", m_axis_tvalid); end
    checks++;
    if (m_axis_tdata !== {320'h0, 64'hC, 64'hB, 64'hA}) begin
      errors++; $display("FAIL partial_data: got lanes %h %h %h %h, required c b a 0", lane(m_axis_tdata, 2), lane(m_axis_tdata, 1), lane(m_axis_tdata, 0), lane(m_axis_tdata, 3));
    end
    checks++;
    if (m_axis_tkeep !== 64'h0000000000FFFFFF || m_axis_tlast !== 1'b1) begin
      errors++; $display("FAIL partial_keep: got tkeep=%h tlast=%b, required 0000000000ffffff 1", m_axis_tkeep, m_axis_tlast);
    end
    idle(2);
    checks++;
    if (seen.size() != 1) begin errors++; $display("FAIL partial_count: got %0d beats, required 1", seen.size()); end
  endtask
  task automatic test_stall();
    int c0;
    m_axis_tready = 0;
    seen.delete();
    c0 = cyc;
    for (int i = 1; i <= 15; i++) send(64'(i), 0);
    checks++;
    if (cyc - c0 != 15) begin errors++; $display("FAIL stall_accept: got %0d cycles for 15 records, required 15", cyc - c0); end
    i_data = '{last: 1'b0, record: 64'd16};
    i_data_vld = 1;
    repeat (4) begin
      @(negedge i_clk);
      checks++;
      if (o_read !== 1'b0) begin errors++; $display("FAIL stall_block: got o_read=%b, required 0", o_read); end
      checks++;
      if (m_axis_tvalid !== 1'b1 || lane(m_axis_tdata, 0) !== 64'd1 || lane(m_axis_tdata, 7) !== 64'd8) begin
        errors++; $display("FAIL stall_hold: got tvalid=%b lane0=%h lane7=%h, required 1 1 8", m_axis_tvalid, lane(m_axis_tdata, 0), lane(m_axis_tdata, 7));
      end
    end
    @(posedge i_clk);
    #1;
    m_axis_tready = 1;
    @(negedge i_clk);
    checks++;
    if (o_read !== 1'b1) begin errors++; $display("FAIL stall_release: got o_read=%b, required 1", o_read); end
    @(posedge i_clk);
    #1;
    i_data_vld = 0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || lane(m_axis_tdata, 0) !== 64'd9 || lane(m_axis_tdata, 7) !== 64'd16 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL stall_reload: got tvalid=%b lane0=%h lane7=%h tlast=%b, required 1 9 16 0", m_axis_tvalid, lane(m_axis_tdata, 0), lane(m_axis_tdata, 7), m_axis_tlast);
    end
    for (int i = 17; i <= 20; i++) send(64'(i), i == 20);
    idle(2);
    checks++;
    if (seen.size() != 3) begin
      errors++; $display("FAIL stall_count: got %0d beats, required 3", seen.size());
    end else begin
      checks++;
      if (lane(seen[2].d, 0) !== 64'd17 || seen[2].k !== 64'hFFFFFFFF || seen[2].l !== 1'b1) begin
        errors++; $display("FAIL stall_tail: got lane0=%h tkeep=%h tlast=%b, required 17 ffffffff 1", lane(seen[2].d, 0), seen[2].k, seen[2].l);
      end
    end
  endtask
  task automatic test_all_last();
    m_axis_tready = 1;
    seen.delete();
    for (int i = 0; i < 6; i++) send(64'(100 + i), 1);
    idle(2);
    checks++;
    if (seen.size() != 6) begin
      errors++; $display("FAIL all_last_count: got %0d beats, required 6", seen.size());
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen[i].d !== {448'h0, 64'(100 + i)} || seen[i].k !== 64'hFF || seen[i].l !== 1'b1) begin
          errors++; $display("FAIL all_last_beat: beat %0d got lane0=%h tkeep=%h tlast=%b, required %0d ff 1", i, lane(seen[i].d, 0), seen[i].k, seen[i].l, 100 + i);
        end
        if (i > 0) begin
          checks++;
          if (seen[i].c - seen[i-1].c != 1) begin
            errors++; $display("FAIL all_last_rate: beat %0d got gap %0d, required 1", i, seen[i].c - seen[i-1].c);
          end
        end
      end
  endtask
  task automatic test_reset_mid();
    m_axis_tready = 0;
    for (int i = 0; i < 8; i++) send(64'(300 + i), 0);
    for (int i = 0; i < 5; i++) send(64'(310 + i), 0);
    #2;
    i_rst_n = 0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
      errors++; $display("FAIL reset_mid_async: got tvalid=%b tkeep=%h tlast=%b, required 0 0 0", m_axis_tvalid, m_axis_tkeep, m_axis_tlast);
    end
    i_data = '{last: 1'b0, record: 64'd999};
    i_data_vld = 1;
    @(negedge i_clk);
    checks++;
    if (o_read !== 1'b0) begin errors++; $display("FAIL reset_mid_read: got %b, required 0", o_read); end
    @(posedge i_clk);
    #3;
    i_data_vld = 0;
    i_rst_n = 1;
    m_axis_tready = 1;
    idle(1);
    seen.delete();
    for (int i = 0; i < 8; i++) send(64'(200 + i), 0);
    idle(2);
    checks++;
    if (seen.size() != 1) begin
      errors++; $display("FAIL reset_mid_count: got %0d beats, required 1", seen.size());
    end else
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (lane(seen[0].d, k) !== 64'(200 + k)) begin
          errors++; $display("FAIL reset_mid_lane: lane %0d got %h, required %0d", k, lane(seen[0].d, k), 200 + k);
        end
      end
  endtask
  task automatic test_random();
    int n = 10000;
    int w = 0;
    n_acc = 0;
    n_out = 0;
    rnd = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom}, i == n - 1 || $urandom_range(0, 9) == 0);
    end
    rnd = 0;
    m_axis_tready = 1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && w < 100) begin
      idle(1);
      w++;
    end
    checks++;
    if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL random_drain: got %0d beats pending tvalid=%b, required 0 0", exp_q.size(), m_axis_tvalid);
    end
    checks++;
    if (n_acc != n || n_out != n) begin
      errors++; $display("FAIL random_count: got accepted=%0d emitted=%0d, required %0d %0d", n_acc, n_out, n, n);
    end
  endtask
  initial begin
    i_rst_n = 0;
    i_data = '0;
    i_data_vld = 0;
    m_axis_tready = 1;
    fork
      monitor();
      forever begin
        @(posedge i_clk);
        #1;
        if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      end
      begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timeout");
      end
    join_none
    test_reset();
    test_two_beats();
    test_partial();
    test_stall();
    test_all_last();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/merge_tree_collect.md
# merge_tree_collect

Rate converter at the root of the merge tree: takes the tree's one-record-per-cycle output stream of `{last, record}` words and packs consecutive records into AXI4-Stream beats for the write-back DMA. It is the output-side counterpart of the leaf dispatch stage. Records are packed lane 0 upward, the same lane order used when beats are unpacked at the leaves. A record flagged `last` closes the current beat early; the beat is padded with zeros and `tlast` is raised.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, 512, output beat width in bits.
- `RECORD_DATA_WIDTH`, 64, record payload width in bits. Elaboration error unless it divides `AXIS_TDATA_WIDTH`, is a multiple of 8, and the quotient is a power of two ≥ 2.

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  RECORD_DATA_WIDTH+1  root output word: bit [RECORD_DATA_WIDTH] is `last`, the low bits are the record.
- `i_data_vld`  in  1  `i_data` is valid. The source is FWFT: data is held until `o_read`.
- `o_read`  out  1  record consumed this cycle.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream accepts the beat.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  packed records.
- `m_axis_tkeep`  out  AXIS_TDATA_WIDTH/8  byte enables for the valid records.
- `m_axis_tlast`  out  1  beat ends a run.

## Operation
- Records per beat: RPB = AXIS_TDATA_WIDTH/RECORD_DATA_WIDTH (8 by default).
- Slot counter `slot`: $clog2(RPB) bits, range 0..RPB-1. It is the lane the next record lands in.
- Pack register holds lanes 0..RPB-2. An accepted non-closing record is written to lane `slot`, and `slot` increments.
- Closing record: an accepted record with `slot == RPB-1` or `last == 1`.
- On a closing record, the output register loads in a single cycle:
  - pack lanes 0..slot-1;
  - the incoming record in lane `slot`;
  - zeros in lanes above `slot`.
  - Also set: `m_axis_tkeep` low (slot+1)·RECORD_DATA_WIDTH/8 bits = 1, all others 0; `m_axis_tlast` = the record's `last` bit.
  - `slot` returns to 0, and the pack register is not cleared.
- `out_free` = !m_axis_tvalid | m_axis_tready.
- `o_read` (combinational) = i_data_vld & (!closing(i_data, slot) | out_free). Non-closing records are always accepted, even while the output is stalled.
- Output register: `m_axis_tvalid` sets when a closing record is accepted. It clears on an `m_axis_tvalid & m_axis_tready` handshake with no new closing record in the same cycle.
  - If a handshake and a new closing record coincide, the register reloads and `m_axis_tvalid` stays 1.
  - `tdata`, `tkeep` and `tlast` are stable while `tvalid & !tready`.
- A `last` record in slot 0 produces a one-record beat: tkeep = 0x00000000000000FF (default parameters).
- No timeout or flush: a partial beat without a `last` record is held indefinitely.

## Timing
- Reset values: `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tkeep` 0, `m_axis_tlast` 0, `slot` 0, pack register 0. `o_read` is 0 whenever `i_rst_n` is 0.
- Reset mid-operation: a partial pack and any pending beat are discarded, and `tvalid` drops asynchronously. After release, packing restarts at lane 0.
- Latency: closing record accepted in cycle N → beat valid in cycle N+1.
- Throughput: 1 record/cycle sustained with `m_axis_tready` held high. A full beat is produced every RPB cycles with no bubbles.
- Stall bound while `m_axis_tready` = 0:
  - at most RPB-1 further records are accepted after the held beat;
  - the next closing record then blocks `o_read` until `out_free`.
- No combinational path from `m_axis_tready` to `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep` or `m_axis_tlast`. A path from `m_axis_tready` to `o_read` is allowed.

## Structure
- Shared package `merge_tree_pkg`:
  - function `records_per_beat(axis_w, rec_w)`;
  - function `keep_mask(slot)`, returning the tkeep pattern for lanes 0..slot;
  - typedef for the `{last, record}` word.
- Single module with no sub-module. Lane write-enables are decoded from `slot` inline.

## Test plan
- 16 records, values 1..16, `last` on record 16, tready=1 → two beats in consecutive 8-cycle windows: lane k = k+1 then k+9. tkeep all-ones for both beats. tlast = 0 for the first beat, 1 for the second.
- 3 records 0xA, 0xB, 0xC with `last` on 0xC → one beat:
  - lanes 0..2 = A, B, C, lanes 3..7 = 0;
  - tkeep = 0x0000000000FFFFFF, tlast = 1;
  - tvalid in the cycle after 0xC is read.
- tready=0 with 20 continuous records → first beat held stable. `o_read` pulses for records 1..15 and stays low with record 16 presented. When tready rises, beat 1 is accepted and beat 2 loads in the same cycle with tvalid unbroken.
- Every record flagged `last` (init-pass style), tready=1 → one beat per record, tkeep = 0xFF, tlast = 1, one beat per cycle.
- Assert `i_rst_n` = 0 after 5 records → tvalid, tkeep and tlast are 0 immediately. After release, 8 new records appear in lanes 0..7 with no trace of the pre-reset data.
- Random `i_data_vld` and `m_axis_tready` for 10k records → a scoreboard shows:
  - record order and values are preserved;
  - no record is lost or duplicated;
  - AXIS stability assertions hold.
